// File: rtl/qs_fetch_if.sv
// -----------------------------------------------------------------------------
// qs_fetch_if : bundle between the qs fetch sequencer and its surroundings
//               (control from execute/top, instruction RAM port, decode port).
//
// Signals
//   start_vld / start_pc       : begin execution at start_pc
//   busy / done                : sequencer activity, one-cycle completion pulse
//   imem_en / imem_addr        : instruction RAM read request
//   imem_rdata                 : RAM data, valid the cycle after imem_en
//   inst_vld / inst / inst_pc  : head of the instruction queue towards decode
//   inst_accept                : decode consumes the head
//   redirect_vld / redirect_pc : control transfer resolved in execute
//
// Modports
//   master : the fetch sequencer
//   slave  : the environment (RAM, decode, execute, top-level control)
// -----------------------------------------------------------------------------
interface qs_fetch_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              start_vld;
    logic [PC_W-1:0]   start_pc;
    logic              busy;
    logic              done;
    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_vld;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_accept;
    logic              redirect_vld;
    logic [PC_W-1:0]   redirect_pc;

    modport master (
        input  start_vld, start_pc, imem_rdata, inst_accept, redirect_vld, redirect_pc,
        output busy, done, imem_en, imem_addr, inst_vld, inst, inst_pc
    );

    modport slave (
        output start_vld, start_pc, imem_rdata, inst_accept, redirect_vld, redirect_pc,
        input  busy, done, imem_en, imem_addr, inst_vld, inst, inst_pc
    );
endinterface

// File: rtl/qs_fetch_seq.sv
// -----------------------------------------------------------------------------
// qs_fetch_seq : instruction fetch sequencer for the qs engine.
//   Owns the PC, reads the 256x16 instruction RAM (1-cycle read latency) and
//   buffers returned instructions in a small registered FIFO for decode.
//   Handles program start, redirects from execute and stopping on WAIT or
//   invalid opcodes.
//
// Ports
//   clk    : clock
//   rst_n  : synchronous reset, active low
//   bus    : qs_fetch_if.master (start, busy/done, RAM read port, decode port,
//            redirect)
//   perf_fetched / perf_discarded / perf_stall : 16-bit saturating counters,
//            present only when QS_FETCH_PERF_EN is defined
//
// Optional feature macro: QS_FETCH_PERF_EN
// -----------------------------------------------------------------------------
module qs_fetch_seq #(
    parameter int PC_W    = 8,
    parameter int INST_W  = 16,
    parameter int Q_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    qs_fetch_if.master  bus
`ifdef QS_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_discarded,
    output logic [15:0] perf_stall
`endif
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]        state;
    logic [PC_W-1:0]   pc;
    logic              epoch;
    logic              done_q;

    // Read in flight towards the RAM (issued last cycle)
    logic              vld_p1;
    logic              epoch_p1;
    logic [PC_W-1:0]   pc_p1;

    // Instruction queue
    logic [INST_W-1:0] q_inst [Q_DEPTH];
    logic [PC_W-1:0]   q_pc   [Q_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop;
    logic              redir;
    logic              start_acc;
    logic              ret_keep;
    logic              issue;
    logic              stop_exit;
    logic [CNT_W:0]    occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(Q_DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    // WAIT (CNTRL with bit11 clear) and any opcode outside the defined set halt fetch
    function automatic logic stops_fetch(input logic [INST_W-1:0] ins);
        case (ins[INST_W-1 -: 4])
            4'b1111: return ~ins[INST_W-5];
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b0110, 4'b0111, 4'b1100: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign bus.inst_vld  = (count != '0);
    assign bus.inst      = q_inst[rd_ptr];
    assign bus.inst_pc   = q_pc[rd_ptr];
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc;

    assign pop       = bus.inst_vld & bus.inst_accept;
    assign redir     = bus.redirect_vld & (state != ST_IDLE);
    assign start_acc = bus.start_vld & (state == ST_IDLE);
    // A redirect in the same cycle makes the returning read wrong-path
    assign ret_keep  = vld_p1 & (epoch_p1 == epoch) & (state == ST_RUN) & ~redir;
    // Credit: entries held plus read in flight, minus the one leaving this cycle
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
    assign issue     = (state == ST_RUN) & (occupancy < (CNT_W+1)'(Q_DEPTH));
    assign stop_exit = (state == ST_STOP) & pop & (count == CNT_W'(1)) & ~redir;

    // ---- stage p0 -> p1 : read issued, tag with PC and epoch ----
    always_ff @(posedge clk) begin
        epoch_p1 <= epoch;
        pc_p1    <= pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= '0;
            epoch  <= 1'b0;
            vld_p1 <= 1'b0;
            done_q <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            vld_p1 <= issue;
            done_q <= stop_exit;
            epoch  <= epoch ^ redir;

            // ---- stage p1 -> queue : return data registered at the tail ----
            if (redir) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                if (ret_keep) begin
                    q_inst[wr_ptr] <= bus.imem_rdata;
                    q_pc[wr_ptr]   <= pc_p1;
                    wr_ptr         <= ptr_inc(wr_ptr);
                end
                count <= count + CNT_W'(ret_keep) - CNT_W'(pop);
            end

            if (redir)
                pc <= bus.redirect_pc;
            else if (start_acc)
                pc <= bus.start_pc;
            else if (issue)
                pc <= pc + PC_W'(1);

            case (state)
                ST_IDLE: if (bus.start_vld) state <= ST_RUN;
                ST_RUN: begin
                    if (!redir && ret_keep && stops_fetch(bus.imem_rdata))
                        state <= ST_STOP;
                end
                ST_STOP: begin
                    if (redir)
                        state <= ST_RUN;
                    else if (stop_exit)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef QS_FETCH_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF))
            return v + 16'd1;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || start_acc) begin
            perf_fetched   <= '0;
            perf_discarded <= '0;
            perf_stall     <= '0;
        end else begin
            perf_fetched   <= sat_inc(perf_fetched, ret_keep);
            perf_discarded <= sat_inc(perf_discarded, vld_p1 & ~ret_keep);
            perf_stall     <= sat_inc(perf_stall, (state == ST_RUN) & ~bus.inst_vld);
        end
    end
`endif

endmodule
